// File: rtl/two_demux_buf_if.sv
// Handshake bundle for the two-channel demux buffer: one tagged input stream, two output streams.
// TWO_DEMUX_STATS_EN adds the per-channel push counters.
interface two_demux_buf_if #(
    parameter int W = 4
);
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         in_en;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
`ifdef TWO_DEMUX_STATS_EN
    logic [7:0]   a_count;
    logic [7:0]   b_count;
`endif

    modport master (
        output in_data, in_sel, in_en, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid
`ifdef TWO_DEMUX_STATS_EN
        , input a_count, b_count
`endif
    );

    modport slave (
        input  in_data, in_sel, in_en, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid
`ifdef TWO_DEMUX_STATS_EN
        , output a_count, b_count
`endif
    );
endinterface

// File: rtl/two_demux_buf.sv
// Steers a tagged word stream into two independent FIFOs (A when in_sel=1, B otherwise).
// Optional feature macro: TWO_DEMUX_STATS_EN (saturating per-channel push counters).
module two_demux_buf #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    two_demux_buf_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(DEPTH);

    // Channel index 0 is A, 1 is B.
    logic [W-1:0]  mem    [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [PW:0]   occ    [2];
    logic [1:0]    full;
    logic [1:0]    empty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    ready;
    logic          in_ready;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < 2; c++) begin
            full[c]  = (occ[c] == OCC_FULL);
            empty[c] = (occ[c] == '0);
        end
    end

    // Held low during reset so no word can be accepted while state is cleared.
    assign in_ready = rst_n & bus.in_en & ~(bus.in_sel ? full[0] : full[1]);
    assign ready    = {bus.b_ready, bus.a_ready};
    assign push[0]  = bus.in_valid & in_ready & bus.in_sel;
    assign push[1]  = bus.in_valid & in_ready & ~bus.in_sel;
    assign pop      = ~empty & ready;

    assign bus.in_ready = in_ready;
    assign bus.a_valid  = ~empty[0];
    assign bus.b_valid  = ~empty[1];
    assign bus.a_data   = mem[0][rd_ptr[0]];
    assign bus.b_data   = mem[1][rd_ptr[1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem[c][d] <= '0;
                end
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem[c][wr_ptr[c]] <= bus.in_data;
                    wr_ptr[c]         <= wr_ptr[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                if (push[c] && !pop[c]) begin
                    occ[c] <= occ[c] + 1'b1;
                end else if (!push[c] && pop[c]) begin
                    occ[c] <= occ[c] - 1'b1;
                end
            end
        end
    end

`ifdef TWO_DEMUX_STATS_EN
    logic [7:0] push_cnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt[0] <= '0;
            push_cnt[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c] && (push_cnt[c] != 8'hFF)) begin
                    push_cnt[c] <= push_cnt[c] + 8'd1;
                end
            end
        end
    end

    assign bus.a_count = push_cnt[0];
    assign bus.b_count = push_cnt[1];
`endif
endmodule

// File: tb/tb_two_demux_buf.sv
// Directed bench for two_demux_buf (W=4, DEPTH=2); counter checks only when TWO_DEMUX_STATS_EN is set.
module tb_two_demux_buf;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    two_demux_buf_if #(.W(4)) bus ();

    two_demux_buf #(.W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_data  = 4'h0;
        bus.in_sel   = 1'b0;
        bus.in_en    = 1'b1;
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 4'h5;
        #2;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
        checks++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got a=%b b=%b exp 0 0", bus.a_valid, bus.b_valid); end
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (bus.a_data !== 4'h0 || bus.b_data !== 4'h0) begin errors++; $display("FAIL rel_data: got a=%h b=%h exp 0 0", bus.a_data, bus.b_data); end
        bus.in_en = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rel_en0_ready: got %b exp 0", bus.in_ready); end
        bus.in_en = 1'b1;
        // Reset arriving between edges with a word already stored.
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 4'h9;
        step();
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h9) begin errors++; $display("FAIL pre_mid_rst: got v=%b d=%h exp 1 9", bus.a_valid, bus.a_data); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.a_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.a_data !== 4'h0) begin errors++; $display("FAIL mid_rst: got v=%b rdy=%b d=%h exp 0 0 0", bus.a_valid, bus.in_ready, bus.a_data); end
        step();
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 4'h7;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.b_valid !== 1'b1 || bus.b_data !== 4'h7 || bus.a_valid !== 1'b0) begin errors++; $display("FAIL post_rst_push: got bv=%b bd=%h av=%b exp 1 7 0", bus.b_valid, bus.b_data, bus.a_valid); end
    endtask

    task automatic test_routing();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 4'b0101;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_ready: got %b exp 1", bus.in_ready); end
        step();
        bus.in_sel  = 1'b0;
        bus.in_data = 4'b1000;
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'b0101 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL route_a: got av=%b ad=%b bv=%b exp 1 0101 0", bus.a_valid, bus.a_data, bus.b_valid); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.b_valid !== 1'b1 || bus.b_data !== 4'b1000) begin errors++; $display("FAIL route_b: got bv=%b bd=%b exp 1 1000", bus.b_valid, bus.b_data); end
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'b0101) begin errors++; $display("FAIL route_a_hold: got av=%b ad=%b exp 1 0101", bus.a_valid, bus.a_data); end
`ifdef TWO_DEMUX_STATS_EN
        checks++; if (bus.a_count !== 8'd1 || bus.b_count !== 8'd1) begin errors++; $display("FAIL route_counts: got a=%0d b=%0d exp 1 1", bus.a_count, bus.b_count); end
`endif
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        step();
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        checks++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL route_drain: got a=%b b=%b exp 0 0", bus.a_valid, bus.b_valid); end
    endtask

    task automatic test_enable();
        bus.in_en    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 4'b0110;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL en_ready: got %b exp 0", bus.in_ready); end
        step();
        bus.in_sel = 1'b0;
        step();
        checks++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin errors++; $display("FAIL en_valid: got a=%b b=%b exp 0 0", bus.a_valid, bus.b_valid); end
`ifdef TWO_DEMUX_STATS_EN
        checks++; if (bus.a_count !== 8'd1 || bus.b_count !== 8'd1) begin errors++; $display("FAIL en_counts: got a=%0d b=%0d exp 1 1", bus.a_count, bus.b_count); end
`endif
        bus.in_valid = 1'b0;
        bus.in_en    = 1'b1;
    endtask

    task automatic test_full();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 4'h1;
        step();
        bus.in_data = 4'h2;
        step();
        bus.in_data = 4'h3;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_stall: got %b exp 0", bus.in_ready); end
        step();
        checks++; if (bus.a_data !== 4'h1) begin errors++; $display("FAIL full_head: got %h exp 1", bus.a_data); end
        bus.in_sel  = 1'b0;
        bus.in_data = 4'b0100;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_b_ready: got %b exp 1", bus.in_ready); end
        step();
        checks++; if (bus.b_valid !== 1'b1 || bus.b_data !== 4'b0100) begin errors++; $display("FAIL full_b_word: got v=%b d=%b exp 1 0100", bus.b_valid, bus.b_data); end
        // Full A being popped this cycle still refuses the incoming A word.
        bus.in_sel  = 1'b1;
        bus.in_data = 4'h3;
        bus.a_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b exp 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'h2) begin errors++; $display("FAIL full_second: got v=%b d=%h exp 1 2", bus.a_valid, bus.a_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_freed: got %b exp 1", bus.in_ready); end
        step();
        bus.a_ready = 1'b0;
        checks++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b1) begin errors++; $display("FAIL full_drained: got a=%b b=%b exp 0 1", bus.a_valid, bus.b_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.a_ready  = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 4'(i);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready[%0d]: got %b exp 1", i, bus.in_ready); end
            step();
            checks++; if (bus.a_valid !== 1'b1 || bus.a_data !== 4'(i)) begin errors++; $display("FAIL wrap_data[%0d]: got v=%b d=%h exp 1 %h", i, bus.a_valid, bus.a_data, 4'(i)); end
        end
        bus.in_valid = 1'b0;
        step();
        bus.a_ready = 1'b0;
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b exp 0", bus.a_valid); end
    endtask

`ifdef TWO_DEMUX_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.b_ready  = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in_data = 4'(i);
            if (i == 254) begin
                #1;
                checks++; if (bus.b_count !== 8'd254) begin errors++; $display("FAIL stats_mid: got %0d exp 254", bus.b_count); end
            end
            step();
        end
        bus.in_valid = 1'b0;
        step();
        bus.b_ready = 1'b0;
        checks++; if (bus.b_count !== 8'hFF || bus.a_count !== 8'h00) begin errors++; $display("FAIL stats_sat: got b=%h a=%h exp ff 00", bus.b_count, bus.a_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_enable();
        test_full();
        test_wrap();
`ifdef TWO_DEMUX_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
